// File: rtl/multi_engine_station.sv
// multi_engine_station: ring station that dispatches tokens to local engines or forwards them through a shared output FIFO
//   in_*       ring token input from the previous station
//   eng_in_*   dispatch of ring tokens to the local engines
//   eng_out_*  tokens emitted by the engines, queued in the output FIFO
//   out_*      FIFO head toward the next station
//   elaborating_chars / full / running   status reported to the controller
module multi_engine_station #(
    parameter int PC_WIDTH        = 8,
    parameter int CC_ID_BITS      = 2,
    parameter int ENGINE_COUNT    = 2,
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int ARB_MODE        = 0
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    input  logic [PC_WIDTH+CC_ID_BITS-1:0]                   in_data,
    output logic                                             in_ready,
    output logic [ENGINE_COUNT-1:0]                          eng_in_valid,
    output logic [ENGINE_COUNT*(PC_WIDTH+CC_ID_BITS)-1:0]    eng_in_data,
    input  logic [ENGINE_COUNT-1:0]                          eng_in_ready,
    input  logic [ENGINE_COUNT-1:0]                          eng_out_valid,
    input  logic [ENGINE_COUNT*(PC_WIDTH+CC_ID_BITS)-1:0]    eng_out_data,
    output logic [ENGINE_COUNT-1:0]                          eng_out_ready,
    output logic                                             out_valid,
    output logic [PC_WIDTH+CC_ID_BITS-1:0]                   out_data,
    input  logic                                             out_ready,
    output logic [2**CC_ID_BITS-1:0]                         elaborating_chars,
    output logic                                             full,
    output logic                                             running
);
    localparam int W     = PC_WIDTH + CC_ID_BITS;
    localparam int N     = ENGINE_COUNT;
    localparam int DEPTH = 2**FIFO_DEPTH_BITS;
    localparam int NCC   = 2**CC_ID_BITS;
    localparam int PW    = $clog2(N + 2);

    logic [W-1:0]               mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   count;
    logic [FIFO_DEPTH_BITS:0]   cc_cnt [NCC];
    logic [PW-1:0]              disp_ptr, wr_rr;
    logic [N:0]                 req;
    logic [W-1:0]               wr_data;
    logic [CC_ID_BITS-1:0]      wr_cc, rd_cc;
    logic                       any_rdy, fwd_req, disp_go, wr_en, rd_en;
    int                         disp_base, disp_best, disp_idx, wr_base, wr_best, wr_idx;

    assign eng_in_data = {N{in_data}};
    assign out_valid   = (count != '0) && !rst;
    assign out_data    = mem[rd_ptr];
    assign full        = count[FIFO_DEPTH_BITS];
    assign running     = (count != '0) || (|eng_out_valid) || in_valid;
    assign wr_cc       = wr_data[W-1 -: CC_ID_BITS];
    assign rd_cc       = out_data[W-1 -: CC_ID_BITS];

    // Both arbiters pick the requester with the smallest rotational distance from
    // their base index; base 0 gives fixed priority, the RR pointer gives round-robin.
    always_comb begin
        any_rdy   = |eng_in_ready;
        fwd_req   = in_valid && !any_rdy;
        req       = {eng_out_valid, fwd_req};
        disp_base = (ARB_MODE == 1) ? int'(disp_ptr) : 0;
        wr_base   = (ARB_MODE == 1) ? int'(wr_rr) : 0;
        disp_best = N;
        disp_idx  = 0;
        for (int j = 0; j < N; j++)
            if (eng_in_ready[j] && ((j - disp_base + N) % N) < disp_best) begin
                disp_best = (j - disp_base + N) % N;
                disp_idx  = j;
            end
        wr_best = N + 1;
        wr_idx  = 0;
        for (int j = 0; j <= N; j++)
            if (req[j] && ((j - wr_base + N + 1) % (N + 1)) < wr_best) begin
                wr_best = (j - wr_base + N + 1) % (N + 1);
                wr_idx  = j;
            end
        disp_go       = in_valid && any_rdy && !rst;
        wr_en         = (wr_best <= N) && !full && !rst;
        eng_in_valid  = '0;
        eng_out_ready = '0;
        wr_data       = in_data;
        for (int k = 0; k < N; k++) begin
            eng_in_valid[k]  = disp_go && (disp_idx == k);
            eng_out_ready[k] = wr_en && (wr_idx == k + 1);
            if (wr_idx == k + 1)
                wr_data = eng_out_data[k*W +: W];
        end
        in_ready = disp_go || (wr_en && wr_idx == 0);
        rd_en    = out_valid && out_ready;
    end

    always_comb begin
        elaborating_chars = '0;
        for (int c = 0; c < NCC; c++)
            elaborating_chars[c] = cc_cnt[c] != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            disp_ptr <= '0;
            wr_rr    <= '0;
            for (int c = 0; c < NCC; c++)
                cc_cnt[c] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
                wr_rr       <= PW'((wr_idx + 1) % (N + 1));
            end
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (disp_go)
                disp_ptr <= PW'((disp_idx + 1) % N);
            count <= count + (FIFO_DEPTH_BITS+1)'(wr_en) - (FIFO_DEPTH_BITS+1)'(rd_en);
            for (int c = 0; c < NCC; c++) begin
                if (wr_en && wr_cc == CC_ID_BITS'(c) && !(rd_en && rd_cc == CC_ID_BITS'(c)))
                    cc_cnt[c] <= cc_cnt[c] + 1'b1;
                else if (rd_en && rd_cc == CC_ID_BITS'(c) && !(wr_en && wr_cc == CC_ID_BITS'(c)))
                    cc_cnt[c] <= cc_cnt[c] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multi_engine_station.sv
// tb_multi_engine_station: scoreboard bench for multi_engine_station in fixed-priority and round-robin modes
module tb_multi_engine_station;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           in_valid = 0, in_ready, out_valid, out_ready = 0, full, running;
    logic [W-1:0]   in_data = '0, out_data;
    logic [1:0]     eng_in_valid, eng_in_ready = '0, eng_out_valid = '0, eng_out_ready;
    logic [2*W-1:0] eng_in_data, eng_out_data = '0;
    logic [3:0]     elab;

    logic           b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_full, b_running;
    logic [W-1:0]   b_in_data = '0, b_out_data;
    logic [1:0]     b_eng_in_valid, b_eng_in_ready = '0, b_eng_out_valid = '0, b_eng_out_ready;
    logic [2*W-1:0] b_eng_in_data, b_eng_out_data = '0;
    logic [3:0]     b_elab;

    multi_engine_station #(.ARB_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .eng_in_valid(eng_in_valid), .eng_in_data(eng_in_data), .eng_in_ready(eng_in_ready),
        .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data), .eng_out_ready(eng_out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .elaborating_chars(elab), .full(full), .running(running));

    multi_engine_station #(.ARB_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .eng_in_valid(b_eng_in_valid), .eng_in_data(b_eng_in_data), .eng_in_ready(b_eng_in_ready),
        .eng_out_valid(b_eng_out_valid), .eng_out_data(b_eng_out_data), .eng_out_ready(b_eng_out_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .elaborating_chars(b_elab), .full(b_full), .running(b_running));

    int n_checks = 0;
    int n_fail = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] e0, e1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (!rst && out_valid && out_ready) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut0 unexpected token: got %0h expected none", out_data);
            end else begin
                e0 = q0.pop_front();
                check("dut0 out_data", out_data, e0);
            end
        end

    always @(negedge clk)
        if (!rst && b_out_valid && b_out_ready) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1 unexpected token: got %0h expected none", b_out_data);
            end else begin
                e1 = q1.pop_front();
                check("dut1 out_data", b_out_data, e1);
            end
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int which);
        int k = 0;
        if (which == 0) begin
            out_ready = 1;
            while ((q0.size() != 0 || out_valid) && k < 60) begin
                tick();
                k++;
            end
            check("dut0 drain complete", q0.size() == 0 && !out_valid, 1);
            out_ready = 0;
        end else begin
            b_out_ready = 1;
            while ((q1.size() != 0 || b_out_valid) && k < 60) begin
                tick();
                k++;
            end
            check("dut1 drain complete", q1.size() == 0 && !b_out_valid, 1);
            b_out_ready = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [3:0] elab_exp [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
    int         rr_exp [6] = '{0, 1, 2, 0, 1, 2};
    logic [W-1:0] rr_tok [3] = '{10'h055, 10'h166, 10'h277};
    int g;

    initial begin
        // reset: ready/valid outputs held low even with requests present
        in_valid = 1; eng_in_ready = 2'b11; eng_out_valid = 2'b11;
        @(negedge clk);
        check("reset in_ready", in_ready, 0);
        check("reset eng_in_valid", eng_in_valid, 0);
        check("reset eng_out_ready", eng_out_ready, 0);
        check("reset out_valid", out_valid, 0);
        tick();
        rst = 0; in_valid = 0; eng_in_ready = 0; eng_out_valid = 0;
        @(negedge clk);
        check("post-reset elab", elab, 0);
        check("post-reset full", full, 0);
        check("post-reset out_valid", out_valid, 0);

        // 1: dispatch to the only ready engine
        tick();
        eng_in_ready = 2'b10; in_valid = 1; in_data = 10'h112;
        @(negedge clk);
        check("dispatch eng_in_valid", eng_in_valid, 2'b10);
        check("dispatch in_ready", in_ready, 1);
        check("dispatch eng_in_data", eng_in_data[19:10], 10'h112);
        tick();
        in_valid = 0; eng_in_ready = 0;
        @(negedge clk);
        check("dispatch fifo empty", out_valid, 0);
        check("idle running", running, 0);

        // 2: fixed priority ring, e0, e1
        tick();
        in_valid = 1; in_data = 10'h021; eng_out_valid = 2'b11; eng_out_data = {10'h341, 10'h131};
        @(negedge clk);
        check("fp ring in_ready", in_ready, 1);
        check("fp ring eng_out_ready", eng_out_ready, 0);
        check("fp no fall-through", out_valid, 0);
        q0.push_back(10'h021);
        tick();
        in_valid = 0;
        @(negedge clk);
        check("fp e0 grant", eng_out_ready, 2'b01);
        check("fp out_valid after write", out_valid, 1);
        check("fp head", out_data, 10'h021);
        q0.push_back(10'h131);
        tick();
        eng_out_valid = 2'b10;
        @(negedge clk);
        check("fp e1 grant", eng_out_ready, 2'b10);
        q0.push_back(10'h341);
        tick();
        eng_out_valid = 0;
        drain(0);

        // 3: round-robin write arbitration on dut1
        tick();
        b_in_valid = 1; b_in_data = 10'h055; b_eng_out_valid = 2'b11; b_eng_out_data = {10'h277, 10'h166};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            g = b_in_ready ? 0 : b_eng_out_ready[0] ? 1 : b_eng_out_ready[1] ? 2 : 3;
            check("rr grant order", g, rr_exp[c]);
            q1.push_back(rr_tok[rr_exp[c]]);
            tick();
        end
        b_in_valid = 0; b_eng_out_valid = 0;
        drain(1);

        // round-robin dispatch pointer advances past the granted engine
        tick();
        b_eng_in_ready = 2'b11; b_in_valid = 1; b_in_data = 10'h3c3;
        @(negedge clk);
        check("rr dispatch first", b_eng_in_valid, 2'b01);
        check("rr dispatch in_ready", b_in_ready, 1);
        tick();
        @(negedge clk);
        check("rr dispatch second", b_eng_in_valid, 2'b10);
        tick();
        @(negedge clk);
        check("rr dispatch wrap", b_eng_in_valid, 2'b01);
        tick();
        b_in_valid = 0; b_eng_in_ready = 0;

        // 4: fill to full, read-only cycle, then write resumes
        for (int i = 0; i < 16; i++) begin
            tick();
            in_valid = 1; in_data = 10'(i);
            @(negedge clk);
            check("fill accept", in_ready, 1);
            q0.push_back(10'(i));
        end
        tick();
        in_data = 10'h0aa; eng_out_valid = 2'b11;
        @(negedge clk);
        check("full flag", full, 1);
        check("full in_ready", in_ready, 0);
        check("full eng_out_ready", eng_out_ready, 0);
        tick();
        eng_out_valid = 0; out_ready = 1;
        @(negedge clk);
        check("full read-only in_ready", in_ready, 0);
        tick();
        @(negedge clk);
        check("full drops", full, 0);
        check("write after drop", in_ready, 1);
        q0.push_back(10'h0aa);
        tick();
        in_valid = 0;
        drain(0);

        // 5: per-cc occupancy
        for (int i = 0; i < 4; i++) begin
            tick();
            in_valid = 1; in_data = (i == 0) ? 10'h005 : 10'h2a0 + 10'(i);
            @(negedge clk);
            check("cc write accept", in_ready, 1);
            q0.push_back(in_data);
        end
        tick();
        in_valid = 0;
        @(negedge clk);
        check("elab cc0+cc2", elab, 4'b0101);
        for (int i = 0; i < 4; i++) begin
            tick();
            out_ready = 1;
            tick();
            out_ready = 0;
            @(negedge clk);
            check("elab after read", elab, elab_exp[i]);
        end
        check("elab drained out_valid", out_valid, 0);

        // 6: reset discards queued tokens
        for (int i = 0; i < 5; i++) begin
            tick();
            in_valid = 1; in_data = 10'h101 + 10'(i);
        end
        tick();
        in_valid = 0;
        @(negedge clk);
        check("pre-reset elab", elab, 4'b0010);
        check("pre-reset out_valid", out_valid, 1);
        tick();
        rst = 1; in_valid = 1;
        @(negedge clk);
        check("rst high in_ready", in_ready, 0);
        tick();
        @(negedge clk);
        check("after rst out_valid", out_valid, 0);
        check("after rst elab", elab, 0);
        check("after rst full", full, 0);
        check("after rst in_ready", in_ready, 0);
        tick();
        rst = 0; in_valid = 0;
        @(negedge clk);
        check("after rst release out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
